// File: rtl/seq_alu_pkg.sv
// -----------------------------------------------------------------------------
// seq_alu_pkg
// Shared definitions for the sequential ALU: operation select encodings and
// the controller state type.
// Ports: none (package).
// -----------------------------------------------------------------------------
package seq_alu_pkg;

    // Operation select encodings carried on the sel field of the operand bus
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    // Controller states: waiting for operands, iterating a multiply, holding a result
    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

endpackage

// File: rtl/seq_alu_if.sv
// -----------------------------------------------------------------------------
// seq_alu_if
// Operand/result bus of the sequential ALU.
// Request side : in_valid, in_ready, a, b, cin, sel
// Response side: out_valid, out_ready, s, cout, prod, zero
// Modports     : master = operand producer / result consumer, slave = the ALU.
// -----------------------------------------------------------------------------
interface seq_alu_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 cin;
    logic [1:0]           sel;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     s;
    logic                 cout;
    logic [2*WIDTH-1:0]   prod;
    logic                 zero;

    modport master (
        output in_valid, a, b, cin, sel, out_ready,
        input  in_ready, out_valid, s, cout, prod, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sel, out_ready,
        output in_ready, out_valid, s, cout, prod, zero
    );

endinterface

// File: rtl/seq_alu_shift_add_mul.sv
// -----------------------------------------------------------------------------
// shift_add_mul
// Iterative unsigned multiplier, one multiplier bit per cycle, LSB first.
// Ports:
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset, aborts a running multiply
//   start_i in   load a_i/b_i and begin a WIDTH-cycle multiply
//   a_i     in   WIDTH-bit multiplicand
//   b_i     in   WIDTH-bit multiplier
//   done_o  out  high during the cycle of the final iteration
//   prod_o  out  2*WIDTH-bit product, valid while done_o is high
// -----------------------------------------------------------------------------
module shift_add_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   prod_o
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      count_q;
    logic               run_q;

    // The product is exposed combinationally on the last iteration so the
    // controller can capture it on the same edge the accumulator would update,
    // which keeps the overall multiply latency at WIDTH+1.
    always_comb begin
        acc_d  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        done_o = run_q && (count_q == LAST);
        prod_o = acc_d;
    end

    // Accumulator, shifting multiplicand/multiplier and iteration counter.
    // A start always restarts from a clean accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            run_q    <= 1'b0;
        end else if (start_i) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
            count_q  <= '0;
            run_q    <= 1'b1;
        end else if (run_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + 1'b1;
            if (done_o) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
// Handshaked ALU (ADD, SUB, MUL, AND) on WIDTH-bit unsigned operands with
// registered results held until consumed.
// Ports:
//   clk  in  rising-edge clock
//   rst  in  synchronous active-high reset
//   bus  seq_alu_if.slave: in_valid/in_ready/a/b/cin/sel operand handshake,
//        out_valid/out_ready/s/cout/prod/zero result handshake
// Build option: SEQ_ALU_FAST_MUL_EN selects a single-cycle combinational
// multiplier instead of the iterative shift_add_mul.
// -----------------------------------------------------------------------------
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    seq_alu_if.slave    bus
);
    import seq_alu_pkg::*;

    state_e               state_q;
    state_e               state_d;
    logic                 accept;
    logic                 load_result;
    logic                 start_mul;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_prod;
    logic [WIDTH-1:0]     b_operand;
    logic [WIDTH:0]       sum_ext;
    logic [WIDTH-1:0]     s_d;
    logic                 cout_d;
    logic [2*WIDTH-1:0]   prod_d;
    logic                 zero_d;
    logic [WIDTH-1:0]     s_q;
    logic                 cout_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic                 zero_q;

    assign accept = bus.in_valid && (state_q == IDLE);

`ifdef SEQ_ALU_FAST_MUL_EN
    assign start_mul = 1'b0;
    assign mul_done  = 1'b0;
    assign mul_prod  = (2*WIDTH)'(bus.a) * (2*WIDTH)'(bus.b);
`else
    assign start_mul = accept && (bus.sel == OP_MUL);

    shift_add_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_mul),
        .a_i     (bus.a),
        .b_i     (bus.b),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
    );
`endif

    // Result datapath. ADD/SUB/AND are computed straight from the bus at
    // accept. A multiply result comes from mul_prod, which is either the
    // fast product (at accept) or the iterative product (on its last step).
    always_comb begin
        b_operand = (bus.sel == OP_SUB) ? ~bus.b : bus.b;
        sum_ext   = {1'b0, bus.a} + {1'b0, b_operand} + {{WIDTH{1'b0}}, bus.cin};
        s_d       = sum_ext[WIDTH-1:0];
        cout_d    = sum_ext[WIDTH];
        prod_d    = '0;
        zero_d    = (sum_ext[WIDTH-1:0] == '0);
        if ((state_q == BUSY) || (bus.sel == OP_MUL)) begin
            prod_d = mul_prod;
            s_d    = mul_prod[WIDTH-1:0];
            cout_d = |mul_prod[2*WIDTH-1:WIDTH];
            zero_d = (mul_prod == '0);
        end else if (bus.sel == OP_AND) begin
            s_d    = bus.a & bus.b;
            cout_d = 1'b0;
            zero_d = ((bus.a & bus.b) == '0);
        end
    end

    // Controller next-state logic; results are captured only on the
    // transition into DONE, so outputs stay frozen through BUSY and DONE.
    always_comb begin
        state_d     = state_q;
        load_result = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (start_mul) begin
                        state_d = BUSY;
                    end else begin
                        state_d     = DONE;
                        load_result = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (mul_done) begin
                    state_d     = DONE;
                    load_result = 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output registers, cleared on reset and loaded only when entering DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q    <= '0;
            cout_q <= 1'b0;
            prod_q <= '0;
            zero_q <= 1'b0;
        end else if (load_result) begin
            s_q    <= s_d;
            cout_q <= cout_d;
            prod_q <= prod_d;
            zero_q <= zero_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.s         = s_q;
    assign bus.cout      = cout_q;
    assign bus.prod      = prod_q;
    assign bus.zero      = zero_q;

endmodule
